// File: rtl/music_reader_pkg.sv
// Shared definitions for the music reader.
// Contents: FSM state enum, default end/rest note codes, song record layout.
package music_reader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetchNote,
        StFetchDur,
        StPlay,
        StFinish
    } state_e;

    // Default marker codes; the top module exposes them as overridable parameters.
    localparam logic [7:0] DEF_END_CODE  = 8'hFF;
    localparam logic [7:0] DEF_REST_CODE = 8'h00;

    // A song is a list of 2-byte records: {note code, duration in ticks}.
    localparam int unsigned REC_BYTES     = 2;
    localparam int unsigned REC_NOTE_BYTE = 0;
    localparam int unsigned REC_DUR_BYTE  = 1;

endpackage

// File: rtl/music_reader_if.sv
// Control, ROM and status signals of the music reader bundled into one interface.
// master: the reader (drives rom_addr, note, note_valid, playing, done).
// slave : the environment (drives start, stop, pause, loop, song_sel, tick, rom_data).
interface music_reader_if #(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SONG_W = 4
) ();

    logic              start;
    logic              stop;
    logic              pause;
    logic              loop;
    logic [SONG_W-1:0] song_sel;
    logic              tick;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] note;
    logic              note_valid;
    logic              playing;
    logic              done;

    modport master (
        input  start, stop, pause, loop, song_sel, tick, rom_data,
        output rom_addr, note, note_valid, playing, done
    );

    modport slave (
        output start, stop, pause, loop, song_sel, tick, rom_data,
        input  rom_addr, note, note_valid, playing, done
    );

endinterface

// File: rtl/music_reader_note_timer.sv
// Note duration down-counter.
// Ports: clk, rst (sync, active high), clear (abort), load/load_val (new duration),
//        tick (tempo pulse, already qualified by PLAY), pause (freeze),
//        expire (the tick that consumes the last remaining count).
module note_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    input  logic             pause,
    output logic             expire
);

    logic [CNT_W-1:0] count_q;
    logic             step;

    assign step   = tick & ~pause & (count_q != '0);
    assign expire = step & (count_q == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (step) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/music_reader.sv
// Music reader: walks {note, duration} records of a song in a combinational ROM and
// presents the current note for the tempo-tick-driven duration.
// Ports: clk, rst (sync, active high), bus (music_reader_if.master): start/stop/pause/
//        loop/song_sel/tick controls, rom_addr/rom_data ROM port, note/note_valid/
//        playing/done status (all registered).
module music_reader
    import music_reader_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 24,
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       SONG_W    = 4,
    parameter logic [DATA_W-1:0] END_CODE  = DEF_END_CODE,
    parameter logic [DATA_W-1:0] REST_CODE = DEF_REST_CODE
) (
    input  logic            clk,
    input  logic            rst,
    music_reader_if.master  bus
);

    localparam int unsigned OFS_W = ADDR_W - SONG_W;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] note_q;
    logic [DATA_W-1:0] pending_q;
    logic              valid_q;
    logic              playing_q;
    logic              done_q;

    logic [SONG_W-1:0] slot;
    logic [OFS_W-1:0]  ofs;
    logic              ofs_last;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] slot_base;
    logic              timer_load;
    logic              timer_tick;
    logic              timer_expire;

    // Offset arithmetic stays inside the slot; the song bits never change mid-song.
    assign slot      = addr_q[ADDR_W-1 -: SONG_W];
    assign ofs       = addr_q[OFS_W-1:0];
    assign ofs_last  = &ofs;
    assign addr_inc  = {slot, ofs + OFS_W'(1)};
    assign slot_base = {slot, {OFS_W{1'b0}}};

    assign timer_load = (state_q == StFetchDur) && !ofs_last && (bus.rom_data != '0);
    assign timer_tick = bus.tick && (state_q == StPlay);

    note_timer #(
        .CNT_W (DATA_W)
    ) u_note_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (bus.stop),
        .load     (timer_load),
        .load_val (bus.rom_data),
        .tick     (timer_tick),
        .pause    (bus.pause),
        .expire   (timer_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            note_q    <= '0;
            pending_q <= '0;
            valid_q   <= 1'b0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (bus.stop) begin
            state_q   <= StIdle;
            note_q    <= '0;
            valid_q   <= 1'b0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        addr_q    <= {bus.song_sel, {OFS_W{1'b0}}};
                        playing_q <= 1'b1;
                        state_q   <= StFetchNote;
                    end
                end
                StFetchNote: begin
                    // Running into the last slot byte counts as an end marker.
                    if (bus.rom_data == END_CODE || ofs_last) begin
                        note_q  <= '0;
                        done_q  <= 1'b1;
                        state_q <= StFinish;
                    end else begin
                        pending_q <= bus.rom_data;
                        addr_q    <= addr_inc;
                        state_q   <= StFetchDur;
                    end
                end
                StFetchDur: begin
                    if (ofs_last) begin
                        note_q  <= '0;
                        done_q  <= 1'b1;
                        state_q <= StFinish;
                    end else begin
                        addr_q <= addr_inc;
                        if (bus.rom_data == '0) begin
                            // Zero-length record: skipped, last note stays on the output.
                            state_q <= StFetchNote;
                        end else begin
                            note_q  <= pending_q;
                            valid_q <= (pending_q != REST_CODE);
                            state_q <= StPlay;
                        end
                    end
                end
                StPlay: begin
                    if (timer_expire) begin
                        valid_q <= 1'b0;
                        state_q <= StFetchNote;
                    end
                end
                StFinish: begin
                    if (bus.loop) begin
                        addr_q  <= slot_base;
                        state_q <= StFetchNote;
                    end else begin
                        playing_q <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.rom_addr   = addr_q;
    assign bus.note       = note_q;
    assign bus.note_valid = valid_q;
    assign bus.playing    = playing_q;
    assign bus.done       = done_q;

endmodule
